// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Purpose:
//   Single-issue instruction fetch stage feeding an execute (EX) stage.
//   It holds a 12-bit word-addressed fetch PC, reads instruction memory
//   combinationally through imem_addr/imem_rdata, and registers the fetched
//   word into the EX slot one cycle later. Jumps, jump-registers and taken
//   branches sitting in EX redirect the fetch PC.
//
// Build option:
//   FETCH_DELAY_SLOT_EN
//     - defined:   the word fetched during a redirect cycle (the delay slot)
//                  enters EX as a real instruction.
//     - undefined: that slot is flushed to a NOP bubble (instruction_EX = 0,
//                  valid_EX = 0), so each taken redirect costs one bubble.
//
// Ports:
//   clk              in   1   rising-edge clock
//   rst              in   1   asynchronous, active-high reset
//   stall            in   1   freeze fetch PC and EX registers this cycle
//   pc_src_EX        in   2   00 seq, 01 cond branch, 10 jump, 11 jump-register
//   branch_taken_EX  in   1   qualifies pc_src_EX = 01
//   jr_target_EX     in  32   jump-register value, bits [11:0] are the target
//   imem_addr        out 12   instruction memory word address (fetch PC)
//   imem_rdata       in  32   instruction memory data for imem_addr
//   instruction_EX   out 32   instruction in the EX slot
//   pc_EX            out 12   word address of instruction_EX
//   valid_EX         out  1   EX slot holds a real instruction (0 = bubble)
//
// Flow control:
//   There is no valid/ready handshake here. stall=1 freezes every register
//   for that cycle and masks pc_src_EX; because the EX slot is frozen too, a
//   redirect that was present during the stall is simply seen again on the
//   first cycle with stall=0 and acts then.
// -----------------------------------------------------------------------------
module fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [1:0]  pc_src_EX,
    input  logic        branch_taken_EX,
    input  logic [31:0] jr_target_EX,
    output logic [11:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction_EX,
    output logic [11:0] pc_EX,
    output logic        valid_EX
);

    localparam logic [1:0] SRC_SEQ    = 2'b00;
    localparam logic [1:0] SRC_BRANCH = 2'b01;
    localparam logic [1:0] SRC_JUMP   = 2'b10;
    localparam logic [1:0] SRC_JR     = 2'b11;

    logic [11:0] pc_fetch_q, pc_fetch_d;
    logic [31:0] instr_q,    instr_d;
    logic [11:0] pc_ex_q,    pc_ex_d;
    logic        valid_q,    valid_d;

    logic        redirect;
    logic [11:0] target;

    // Only the low 12 bits of the jump-register value form an address.
    logic        unused_jr_hi;
    assign unused_jr_hi = ^jr_target_EX[31:12];

    // A bubble in EX must never redirect, whatever pc_src_EX says.
    always_comb begin
        redirect = 1'b0;
        if (valid_q && !stall) begin
            case (pc_src_EX)
                SRC_BRANCH: redirect = branch_taken_EX;
                SRC_JUMP:   redirect = 1'b1;
                SRC_JR:     redirect = 1'b1;
                default:    redirect = 1'b0;
            endcase
        end
    end

    // Branch offset is instruction bits [11:0] added to pc+1; the 12-bit
    // sum wraps modulo 4096, so a large offset acts as a backward branch.
    always_comb begin
        target = 12'd0;
        case (pc_src_EX)
            SRC_BRANCH: target = pc_ex_q + 12'd1 + instr_q[11:0];
            SRC_JUMP:   target = instr_q[11:0];
            SRC_JR:     target = jr_target_EX[11:0];
            SRC_SEQ:    target = 12'd0;
            default:    target = 12'd0;
        endcase
    end

    always_comb begin
        pc_fetch_d = pc_fetch_q;
        instr_d    = instr_q;
        pc_ex_d    = pc_ex_q;
        valid_d    = valid_q;
        if (!stall) begin
            // The word at the current fetch PC always moves into EX; only
            // its validity depends on whether a redirect is happening.
            instr_d = imem_rdata;
            pc_ex_d = pc_fetch_q;
            valid_d = 1'b1;
            if (redirect) begin
                pc_fetch_d = target;
`ifdef FETCH_DELAY_SLOT_EN
                // Delay slot executes: keep the normal load above.
`else
                // Flush the wrong-path word into a NOP bubble.
                instr_d = 32'h0000_0000;
                valid_d = 1'b0;
`endif
            end else begin
                pc_fetch_d = pc_fetch_q + 12'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_fetch_q <= 12'd0;
            instr_q    <= 32'h0000_0000;
            pc_ex_q    <= 12'd0;
            valid_q    <= 1'b0;
        end else begin
            pc_fetch_q <= pc_fetch_d;
            instr_q    <= instr_d;
            pc_ex_q    <= pc_ex_d;
            valid_q    <= valid_d;
        end
    end

    assign imem_addr      = pc_fetch_q;
    assign instruction_EX = instr_q;
    assign pc_EX          = pc_ex_q;
    assign valid_EX       = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Drives fetch_unit against a word-array instruction memory. A reference
// model of the fetch/EX behaviour is advanced once per clock by the stimulus
// task, which pushes the expected post-edge outputs into exp_q; a monitor
// pops one entry after every non-reset rising edge and compares.
// Directed scenarios add spot checks at the interesting cycles.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        stall = 1'b0;
    logic [1:0]  pc_src_EX = 2'b00;
    logic        branch_taken_EX = 1'b0;
    logic [31:0] jr_target_EX = 32'h0;
    logic [11:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instruction_EX;
    logic [11:0] pc_EX;
    logic        valid_EX;

    logic [31:0] mem [4096];
    assign imem_rdata = mem[imem_addr];

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .pc_src_EX       (pc_src_EX),
        .branch_taken_EX (branch_taken_EX),
        .jr_target_EX    (jr_target_EX),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .instruction_EX  (instruction_EX),
        .pc_EX           (pc_EX),
        .valid_EX        (valid_EX)
    );

    // ---------------- scoreboard ----------------
    // entry = {imem_addr[11:0], valid, instruction[31:0], pc_EX[11:0]}
    localparam int W = 57;
    logic [W-1:0] exp_q[$];
    int n_total = 0;
    int n_bad   = 0;

    // Reference model state: fetch address and the EX slot contents.
    int          m_pc;
    int          m_pcex;
    logic [31:0] m_instr;
    logic        m_valid;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Monitor: one expected entry per non-reset rising edge.
    always @(posedge clk) begin
        logic [W-1:0] e;
        #1;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (imem_addr !== e[56:45] || valid_EX !== e[44] ||
                instruction_EX !== e[43:12] ||
                (e[44] && pc_EX !== e[11:0])) begin
                n_bad++;
                $display("FAIL scoreboard: got addr=%0h v=%0b instr=%0h pc=%0h expected addr=%0h v=%0b instr=%0h pc=%0h at %0t",
                         imem_addr, valid_EX, instruction_EX, pc_EX,
                         e[56:45], e[44], e[43:12], e[11:0], $time);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Drives one cycle of inputs, advances the model by the architectural
    // rules, queues the expected result and waits past the edge.
    task automatic step(input logic st, input logic [1:0] src, input logic tk,
                        input logic [31:0] jr);
        logic take;
        int   tgt;
        stall = st;
        pc_src_EX = src;
        branch_taken_EX = tk;
        jr_target_EX = jr;
        if (!st) begin
            take = m_valid && (src == 2'd2 || src == 2'd3 || (src == 2'd1 && tk));
            tgt = 0;
            if (src == 2'd1) tgt = (m_pcex + 1 + int'(m_instr[11:0])) % 4096;
            if (src == 2'd2) tgt = int'(m_instr[11:0]);
            if (src == 2'd3) tgt = int'(jr[11:0]);
            m_instr = mem[m_pc];
            m_pcex  = m_pc;
            m_valid = 1'b1;
            if (take) begin
                m_pc = tgt;
`ifndef FETCH_DELAY_SLOT_EN
                m_instr = 32'h0;
                m_valid = 1'b0;
`endif
            end else begin
                m_pc = (m_pc + 1) % 4096;
            end
        end
        exp_q.push_back({m_pc[11:0], m_valid, m_instr, m_pcex[11:0]});
        @(posedge clk);
        #2;
    endtask

    // Asserts reset between clock edges and checks the asynchronous clear.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_addr",  {20'h0, imem_addr}, 32'h0);
        chk("rst_instr", instruction_EX, 32'h0);
        chk("rst_pc",    {20'h0, pc_EX}, 32'h0);
        chk("rst_valid", {31'h0, valid_EX}, 32'h0);
        exp_q.delete();
        m_pc = 0; m_pcex = 0; m_instr = 32'h0; m_valid = 1'b0;
        stall = 1'b0; pc_src_EX = 2'b00; branch_taken_EX = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_until_pc(input int t);
        int n;
        n = 0;
        while (!(m_valid && m_pcex == t) && n < 200) begin
            step(1'b0, 2'b00, 1'b0, 32'h0);
            n++;
        end
        if (n >= 200) begin
            n_total++;
            n_bad++;
            $display("FAIL run_until_pc: pc %0h not reached within 200 cycles", t);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int k = 0; k < 4096; k++) mem[k] = 32'(k + 100);
        mem[5]  = 32'h0000_0040;   // jump to 0x040
        mem[10] = 32'h0000_FFFC;   // branch offset 0xFFC, bits [15:12] ignored

        // Reset, then sequential fetch 100,101,102 at pc 0,1,2.
        do_reset();
        step(1'b0, 2'b00, 1'b0, 32'h0);
        chk("seq0_instr", instruction_EX, 32'd100);
        chk("seq0_pc", {20'h0, pc_EX}, 32'd0);
        chk("seq0_valid", {31'h0, valid_EX}, 32'd1);
        step(1'b0, 2'b00, 1'b0, 32'h0);
        chk("seq1_instr", instruction_EX, 32'd101);
        step(1'b0, 2'b00, 1'b0, 32'h0);
        chk("seq2_pc", {20'h0, pc_EX}, 32'd2);

        // Jump at pc 5 to 0x040.
        run_until_pc(5);
        step(1'b0, 2'b10, 1'b0, 32'h0);
`ifdef FETCH_DELAY_SLOT_EN
        chk("jmp_slot_pc", {20'h0, pc_EX}, 32'd6);
        chk("jmp_slot_valid", {31'h0, valid_EX}, 32'd1);
`else
        chk("jmp_bubble_valid", {31'h0, valid_EX}, 32'd0);
        chk("jmp_bubble_instr", instruction_EX, 32'h0);
`endif
        step(1'b0, 2'b00, 1'b0, 32'h0);
        chk("jmp_target_pc", {20'h0, pc_EX}, 32'h040);
        chk("jmp_target_valid", {31'h0, valid_EX}, 32'd1);

        // Taken branch at pc 10 with offset 0xFFC lands on 7.
        do_reset();
        run_until_pc(10);
        step(1'b0, 2'b01, 1'b1, 32'h0);
        step(1'b0, 2'b00, 1'b0, 32'h0);
        chk("br_taken_pc", {20'h0, pc_EX}, 32'd7);

        // Not-taken branch falls through to 11.
        do_reset();
        run_until_pc(10);
        step(1'b0, 2'b01, 1'b0, 32'h0);
        chk("br_not_taken_pc", {20'h0, pc_EX}, 32'd11);
        chk("br_not_taken_valid", {31'h0, valid_EX}, 32'd1);

        // Jump-register held through a 3-cycle stall.
        do_reset();
        run_until_pc(3);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b11, 1'b0, 32'h0000_0123);
            chk("stall_pc", {20'h0, pc_EX}, 32'd3);
            chk("stall_instr", instruction_EX, 32'd103);
            chk("stall_addr", {20'h0, imem_addr}, 32'd4);
        end
        step(1'b0, 2'b11, 1'b0, 32'h0000_0123);
        chk("jr_addr", {20'h0, imem_addr}, 32'h123);
        step(1'b0, 2'b00, 1'b0, 32'h0);
        chk("jr_target_pc", {20'h0, pc_EX}, 32'h123);

        // Wrap from 4095 to 0, then reset in the middle of a stalled jump.
        do_reset();
        run_until_pc(1);
        step(1'b0, 2'b11, 1'b0, 32'h0000_0FFF);
        step(1'b0, 2'b00, 1'b0, 32'h0);
        chk("wrap_pc_fff", {20'h0, pc_EX}, 32'hFFF);
        step(1'b0, 2'b00, 1'b0, 32'h0);
        chk("wrap_pc_0", {20'h0, pc_EX}, 32'h0);
        step(1'b1, 2'b10, 1'b0, 32'h0);
        step(1'b1, 2'b10, 1'b0, 32'h0);
        do_reset();
        step(1'b0, 2'b00, 1'b0, 32'h0);
        chk("restart_pc", {20'h0, pc_EX}, 32'h0);
        chk("restart_instr", instruction_EX, 32'd100);
        chk("restart_valid", {31'h0, valid_EX}, 32'd1);

        // Randomized phase: random memory image and control inputs.
        for (int k = 0; k < 4096; k++) mem[k] = $urandom;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            step($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom);
        end

        repeat (2) @(posedge clk);
        #3;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
